ctrl_pipe: RTL

Pipelined control unit for the five-stage RV32I core. Decodes the instruction in the decode stage into a control bundle and carries it through EX, MEM and WB. Detects load-use hazards and resolves them with a one-cycle stall plus bubble. Applies branch/jump flushes and a global memory hold, and keeps a saturating stall counter for performance debug.

---
 rtl/ctrl_pkg.sv | 85 ++++++++
 rtl/ctrl_decode.sv | 103 ++++++++++
 rtl/ctrl_pipe.sv | 135 +++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the pipelined RV32I control unit: opcodes,
// control-bundle layout, the bubble constant and branch-type codes.
package ctrl_pkg;

  localparam int CTRL_W = 16;

  // Major opcodes recognised by the decoder
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // Legal funct7 values for register-register ALU ops
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // ALU op codes with a fixed meaning
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  // Bit offsets of each field inside the flat 16-bit bundle
  localparam int CB_REGWRITE     = 15;
  localparam int CB_ALUOP_LSB    = 11;
  localparam int CB_LUISRC       = 10;
  localparam int CB_ALUSRC       = 9;
  localparam int CB_MEMWRITE     = 8;
  localparam int CB_MEMREAD      = 7;
  localparam int CB_MEMTOREG_LSB = 5;
  localparam int CB_JUMPPC       = 4;
  localparam int CB_JUMPCTRL     = 3;
  localparam int CB_BRANCH_LSB   = 0;

  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_BEQ  = 3'b001,
    BR_BNE  = 3'b010,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } branch_e;

  typedef enum logic [1:0] {
    MTR_ALU = 2'b00,
    MTR_MEM = 2'b01,
    MTR_PC4 = 2'b10
  } memtoreg_e;

  // Field order matches the offsets above, MSB first
  typedef struct packed {
    logic       regwrite;
    logic [3:0] aluop;
    logic       luisrc;
    logic       alusrc;
    logic       memwrite;
    logic       memread;
    logic [1:0] memtoreg;
    logic       jumppc;
    logic       jumpcontrol;
    logic [2:0] branch;
  } ctrl_t;

  // A bubble never writes the register file or memory
  localparam ctrl_t BUBBLE = ctrl_t'(16'h0000);

  // Map branch funct3 to the bundle's branch-type code
  function automatic logic [2:0] branch_code(input logic [2:0] funct3);
    logic [2:0] code;
    case (funct3)
      3'b000:  code = BR_BEQ;
      3'b001:  code = BR_BNE;
      3'b100:  code = BR_BLT;
      3'b101:  code = BR_BGE;
      3'b110:  code = BR_BLTU;
      3'b111:  code = BR_BGEU;
      default: code = BR_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational instruction decode: opcode/funct fields in,
// control bundle, illegal flag and register-operand use flags out.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter bit BRANCH_ALL = 1'b1
) (
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output ctrl_t      ctrl_o,
  output logic       illegal_o,
  output logic       rs1_used_o,
  output logic       rs2_used_o
);

  ctrl_t raw_s;
  logic  illegal_s;

  // Per-opcode field decode and detection of unsupported encodings
  always_comb begin
    raw_s     = BUBBLE;
    illegal_s = 1'b0;
    case (opcode_i)
      OPC_LOAD: begin
        raw_s.regwrite = 1'b1;
        raw_s.aluop    = ALU_ADD;
        raw_s.alusrc   = 1'b1;
        raw_s.memread  = 1'b1;
        raw_s.memtoreg = MTR_MEM;
      end
      OPC_STORE: begin
        raw_s.aluop    = ALU_ADD;
        raw_s.alusrc   = 1'b1;
        raw_s.memwrite = 1'b1;
      end
      OPC_LUI: begin
        raw_s.regwrite = 1'b1;
        raw_s.aluop    = ALU_ADD;
        raw_s.luisrc   = 1'b1;
        raw_s.alusrc   = 1'b1;
      end
      OPC_JAL: begin
        raw_s.regwrite    = 1'b1;
        raw_s.aluop       = ALU_ADD;
        raw_s.memtoreg    = MTR_PC4;
        raw_s.jumpcontrol = 1'b1;
      end
      OPC_JALR: begin
        raw_s.regwrite    = 1'b1;
        raw_s.aluop       = ALU_ADD;
        raw_s.alusrc      = 1'b1;
        raw_s.memtoreg    = MTR_PC4;
        raw_s.jumppc      = 1'b1;
        raw_s.jumpcontrol = 1'b1;
      end
      OPC_OP: begin
        raw_s.regwrite = 1'b1;
        raw_s.aluop    = {funct7_i[5], funct3_i};
        if ((funct7_i != F7_BASE) && (funct7_i != F7_ALT)) begin
          illegal_s = 1'b1;
        end else begin
          illegal_s = 1'b0;
        end
      end
      OPC_OPIMM: begin
        // funct7[5] only selects srai vs srli; elsewhere it is immediate data
        raw_s.regwrite = 1'b1;
        raw_s.aluop    = {funct7_i[5] & (funct3_i == 3'b101), funct3_i};
        raw_s.alusrc   = 1'b1;
      end
      OPC_BRANCH: begin
        raw_s.aluop  = ALU_SUB;
        raw_s.branch = branch_code(funct3_i);
        if ((funct3_i == 3'b010) || (funct3_i == 3'b011)) begin
          illegal_s = 1'b1;
        end else if (!BRANCH_ALL && (funct3_i != 3'b001)) begin
          illegal_s = 1'b1;
        end else begin
          illegal_s = 1'b0;
        end
      end
      default: begin
        illegal_s = 1'b1;
      end
    endcase
  end

  // Operand use flags and final bundle (illegal encodings become a bubble)
  always_comb begin
    rs1_used_o = (opcode_i != OPC_LUI) && (opcode_i != OPC_JAL);
    rs2_used_o = (opcode_i == OPC_OP) || (opcode_i == OPC_STORE) ||
                 (opcode_i == OPC_BRANCH);
    if (illegal_s) begin
      ctrl_o    = BUBBLE;
      illegal_o = 1'b1;
    end else begin
      ctrl_o    = raw_s;
      illegal_o = 1'b0;
    end
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Pipelined control unit: decodes in D, carries the bundle through
// E/M/W, inserts a one-cycle bubble on load-use hazards, honours
// flush and memory hold, and counts stall cycles (saturating).
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter bit BRANCH_ALL = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       instr_d,
  input  logic              hold_i,
  input  logic              flush_i,
  output logic [CTRL_W-1:0] ctrl_d,
  output logic              stall_d,
  output logic              illegal_d,
  output logic [CTRL_W-1:0] ctrl_e,
  output logic [CTRL_W-1:0] ctrl_m,
  output logic [CTRL_W-1:0] ctrl_w,
  output logic [REG_AW-1:0] rd_e,
  output logic [REG_AW-1:0] rd_m,
  output logic [REG_AW-1:0] rd_w,
  output logic [CNT_W-1:0]  stall_cnt
);

  ctrl_t             dec_s;
  logic              rs1_used_s;
  logic              rs2_used_s;
  logic [REG_AW-1:0] rs1_s;
  logic [REG_AW-1:0] rs2_s;
  logic [REG_AW-1:0] rd_s;
  logic              stall_s;

  ctrl_t             ctrl_e_q, ctrl_e_d;
  ctrl_t             ctrl_m_q, ctrl_m_d;
  ctrl_t             ctrl_w_q, ctrl_w_d;
  logic [REG_AW-1:0] rd_e_q, rd_e_d;
  logic [REG_AW-1:0] rd_m_q, rd_m_d;
  logic [REG_AW-1:0] rd_w_q, rd_w_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Register fields above REG_AW are ignored (RV32E support)
  assign rs1_s = instr_d[15 +: REG_AW];
  assign rs2_s = instr_d[20 +: REG_AW];
  assign rd_s  = instr_d[7 +: REG_AW];

  ctrl_decode #(
    .BRANCH_ALL (BRANCH_ALL)
  ) u_decode (
    .opcode_i   (instr_d[6:0]),
    .funct3_i   (instr_d[14:12]),
    .funct7_i   (instr_d[31:25]),
    .ctrl_o     (dec_s),
    .illegal_o  (illegal_d),
    .rs1_used_o (rs1_used_s),
    .rs2_used_o (rs2_used_s)
  );

  // Load-use hazard: a load in E feeding a used source in D; flush and hold suppress it
  always_comb begin
    stall_s = 1'b0;
    if (ctrl_e_q.memread && (rd_e_q != {REG_AW{1'b0}}) &&
        ((rs1_used_s && (rs1_s == rd_e_q)) || (rs2_used_s && (rs2_s == rd_e_q))) &&
        !flush_i && !hold_i) begin
      stall_s = 1'b1;
    end else begin
      stall_s = 1'b0;
    end
  end

  // Next state of the stage registers and counter: hold > flush > stall > advance
  always_comb begin
    ctrl_e_d = ctrl_e_q;
    ctrl_m_d = ctrl_m_q;
    ctrl_w_d = ctrl_w_q;
    rd_e_d   = rd_e_q;
    rd_m_d   = rd_m_q;
    rd_w_d   = rd_w_q;
    cnt_d    = cnt_q;
    if (hold_i) begin
      cnt_d = cnt_q;
    end else begin
      ctrl_m_d = ctrl_e_q;
      ctrl_w_d = ctrl_m_q;
      rd_m_d   = rd_e_q;
      rd_w_d   = rd_m_q;
      if (flush_i || stall_s) begin
        ctrl_e_d = BUBBLE;
        rd_e_d   = {REG_AW{1'b0}};
      end else begin
        ctrl_e_d = dec_s;
        rd_e_d   = dec_s.regwrite ? rd_s : {REG_AW{1'b0}};
      end
      if (stall_s && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_d = cnt_q;
      end
    end
  end

  // Stage registers and stall counter; async reset discards everything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_e_q <= BUBBLE;
      ctrl_m_q <= BUBBLE;
      ctrl_w_q <= BUBBLE;
      rd_e_q   <= {REG_AW{1'b0}};
      rd_m_q   <= {REG_AW{1'b0}};
      rd_w_q   <= {REG_AW{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      ctrl_e_q <= ctrl_e_d;
      ctrl_m_q <= ctrl_m_d;
      ctrl_w_q <= ctrl_w_d;
      rd_e_q   <= rd_e_d;
      rd_m_q   <= rd_m_d;
      rd_w_q   <= rd_w_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ctrl_d    = dec_s;
  assign stall_d   = stall_s;
  assign ctrl_e    = ctrl_e_q;
  assign ctrl_m    = ctrl_m_q;
  assign ctrl_w    = ctrl_w_q;
  assign rd_e      = rd_e_q;
  assign rd_m      = rd_m_q;
  assign rd_w      = rd_w_q;
  assign stall_cnt = cnt_q;

endmodule
